mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Word-addressed data memory that sits on the processor side of the memory bus, where the multicycle core's memwrite/adr/writedata are driven, and serves each access with a programmable wait-state latency.
Each committed store is also pushed into a small write-trace FIFO. The system bench or a debug unit drains this FIFO, so it can check every store (for example, value 7 at address 84) without snooping the bus.

Parameters:
ADDR_WIDTH, 6, word-address bits; memory depth is 2**ADDR_WIDTH words of 32 bits
WAIT_CYCLES, 2, wait states inserted between request acceptance and response (0 allowed)
LOG_DEPTH, 4, write-trace FIFO entries (power of two, at least 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  access request, sampled only in IDLE
we  in  1  1 = write, 0 = read; qualified by req
adr  in  32  byte address
wdata  in  32  write data
rdata  out  32  read data, valid while ready=1 on a read
ready  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with ready when the access was misaligned
log_valid  out  1  write-trace FIFO not empty
log_ready  in  1  consumer pop; a pop occurs when log_valid and log_ready are both 1
log_adr  out  32  byte address of the head entry
log_data  out  32  data of the head entry
log_count  out  LOG_DEPTH_BITS+1  current occupancy
log_overflow  out  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, while reset=0):
  - State goes to IDLE; ready=0, err=0, rdata=0.
  - FIFO is emptied: log_valid=0, log_count=0, log_overflow=0.
  - Memory array is not reset; contents persist through reset.
- States: IDLE, WAIT, RESP.
- IDLE, req=1:
  - Latch adr, we and wdata.
  - Load the wait counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise go to RESP.
- WAIT:
  - Decrement the counter each cycle.
  - Go to RESP when the counter equals 1 at the clock edge.
  - req, adr, we and wdata are ignored.
- RESP (one cycle), then IDLE:
  - ready=1.
  - Aligned read: rdata = mem[adr[ADDR_WIDTH+1:2]].
  - Aligned write: write mem at the RESP clock edge and push {adr, wdata} to the FIFO.
  - Misaligned access (adr[1:0]!=0): err=1, rdata=0, no memory write, no log push.
- Latency: ready is high exactly WAIT_CYCLES+1 cycles after the edge that samples req. Back-to-back accesses are possible, with req sampled again in the IDLE cycle after RESP.
- A req held high continuously starts a new access each time the block re-enters IDLE.
- Address wrap: bits above ADDR_WIDTH+1 are ignored. Example with ADDR_WIDTH=6: byte 256 aliases byte 0. No error is raised.
- Read-after-write: a read of the same word in the next access returns the newly written data.
- rdata holds its last value outside RESP.
- FIFO boundaries:
  - Push when full with no pop: entry dropped, log_overflow set, log_count unchanged.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
  - Push when empty: log_valid rises the next cycle (no fall-through).
  - Pointers wrap modulo LOG_DEPTH.
- Reset mid-access (in WAIT or RESP): the pending access is discarded, with no memory write and no log entry.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the word-index derivation constant;
  - the log entry width (64 = address + data).
- One sub-module, trace_fifo: synchronous FIFO with push, pop, full, empty, count and sticky overflow.
- mem_responder holds the FSM, the wait counter and the memory array.

Test Plan:
- Reset, then write 84←7 with WAIT_CYCLES=2 → ready pulses 3 cycles after req; log_valid=1 the next cycle with log_adr=84, log_data=7; log_count=1.
- Write 80←5, then read 80 → read ready with rdata=5; after the write, log holds entry 80/5.
- Read adr=0x102 (misaligned) → ready=1 with err=1, rdata=0, no log push; memory at 0x100 unchanged.
- 5 writes (addresses 0,4,8,12,16) with log_ready=0 and LOG_DEPTH=4 → log_count=4, log_overflow=1, head entry is address 0. Then pop 4 → addresses 0,4,8,12 in order, log_valid=0.
- Full FIFO with log_ready=1 during the 5th write → both push and pop succeed, log_overflow stays 0, log_count stays 4.
- Assert reset during WAIT of a write 84←9 → no ready pulse, log empty, log_overflow=0; a later read of 84 returns the pre-reset value (7 if the first scenario ran first). With WAIT_CYCLES=0, ready arrives 1 cycle after req.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the wait-state memory responder and its
// write-trace FIFO.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   // Byte address bit where the word index starts (32-bit words).
   localparam int WORD_LSB = 2;

   // One trace entry is {byte address, write data}.
   localparam int LOG_ENTRY_W = 64;

   function automatic logic is_misaligned(input logic [31:0] a);
      return a[WORD_LSB-1:0] != '0;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Processor-side memory bus plus the write-trace drain port of mem_responder.
interface mem_responder_if #(
   parameter int LOG_DEPTH = 4
);
   localparam int LOG_DEPTH_BITS = $clog2(LOG_DEPTH);

   logic                    req;
   logic                    we;
   logic [31:0]             adr;
   logic [31:0]             wdata;
   logic [31:0]             rdata;
   logic                    ready;
   logic                    err;
   logic                    log_valid;
   logic                    log_ready;
   logic [31:0]             log_adr;
   logic [31:0]             log_data;
   logic [LOG_DEPTH_BITS:0] log_count;
   logic                    log_overflow;

   modport master (
      output req, we, adr, wdata, log_ready,
      input  rdata, ready, err, log_valid, log_adr, log_data, log_count, log_overflow
   );

   modport slave (
      input  req, we, adr, wdata, log_ready,
      output rdata, ready, err, log_valid, log_adr, log_data, log_count, log_overflow
   );

endinterface

// File: rtl/mem_responder_trace_fifo.sv
// Synchronous FIFO for committed stores; drops pushes when full and records
// the loss in a sticky overflow flag.
module trace_fifo
   import mem_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = LOG_ENTRY_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] store_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             full, pop_ok, push_ok;

   always_comb begin
      // NOTE: every signal gets a value on every path, so no latch is inferred.
      full     = (count_q == (PW+1)'(DEPTH));
      pop_ok   = pop_i && (count_q != '0);
      push_ok  = push_i && (!full || pop_ok);
      wr_ptr_d = wr_ptr_q + PW'(push_ok);
      rd_ptr_d = rd_ptr_q + PW'(pop_ok);
      count_d  = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
      ovf_d    = ovf_q | (push_i & full & ~pop_ok);
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // NOTE: storage has no reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push_ok) store_q[wr_ptr_q] <= din_i;
   end

   assign dout_o     = store_q[rd_ptr_q];
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed data memory with programmable wait states; every aligned
// committed store is also logged into trace_fifo.
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 6,
   parameter int WAIT_CYCLES = 2,
   parameter int LOG_DEPTH   = 4
) (
   input  logic            clk,
   input  logic            reset,
   mem_responder_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [31:0]             adr_q, wdata_q, rdata_q;
   logic                    we_q, ready_q, err_q;
   logic [31:0]             mem_q [DEPTH];

   logic [31:0]             acc_adr_d, rdata_d;
   logic                    acc_we_d, err_d, log_push;
   logic [LOG_ENTRY_W-1:0]  log_head;
   logic                    log_empty;

   // With no wait states the response is formed straight from the bus.
   always_comb begin
      acc_adr_d = (state_q == IDLE) ? bus.adr : adr_q;
      acc_we_d  = (state_q == IDLE) ? bus.we  : we_q;
      err_d     = is_misaligned(acc_adr_d);
      if (err_d)         rdata_d = '0;
      else if (acc_we_d) rdata_d = rdata_q;
      else               rdata_d = mem_q[acc_adr_d[ADDR_WIDTH+WORD_LSB-1:WORD_LSB]];
      log_push  = (state_q == RESP) && we_q && !is_misaligned(adr_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req) begin
                  adr_q   <= bus.adr;
                  we_q    <= bus.we;
                  wdata_q <= bus.wdata;
                  cnt_q   <= CNT_W'(WAIT_CYCLES);
                  if (WAIT_CYCLES == 0) begin
                     state_q <= RESP;
                     ready_q <= 1'b1;
                     err_q   <= err_d;
                     rdata_q <= rdata_d;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= RESP;
                  ready_q <= 1'b1;
                  err_q   <= err_d;
                  rdata_q <= rdata_d;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Store commits on the edge that ends RESP, together with the log push.
   always_ff @(posedge clk) begin
      if (log_push) mem_q[adr_q[ADDR_WIDTH+WORD_LSB-1:WORD_LSB]] <= wdata_q;
   end

   trace_fifo #(
      .DEPTH (LOG_DEPTH),
      .WIDTH (LOG_ENTRY_W)
   ) u_trace_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (log_push),
      .din_i      ({adr_q, wdata_q}),
      .pop_i      (bus.log_ready),
      .dout_o     (log_head),
      .empty_o    (log_empty),
      .count_o    (bus.log_count),
      .overflow_o (bus.log_overflow)
   );

   assign bus.rdata     = rdata_q;
   assign bus.ready     = ready_q;
   assign bus.err       = err_q;
   assign bus.log_valid = !log_empty;
   assign bus.log_adr   = log_head[LOG_ENTRY_W-1:32];
   assign bus.log_data  = log_head[31:0];

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded bench for mem_responder: stimulus queues expected responses,
// a monitor pops and compares on every ready pulse.
module tb_mem_responder;
   import mem_pkg::*;

   localparam int W = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_responder_if #(.LOG_DEPTH(4)) bus  ();
   mem_responder_if #(.LOG_DEPTH(4)) bus0 ();

   mem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(W), .LOG_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   mem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(0), .LOG_DEPTH(4)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        chk_rdata;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] mdl [64];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Issues one access from a negedge; returns at the negedge of its RESP cycle.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      logic mis;
      @(negedge clk);
      mis         = (a[1:0] != 2'b00);
      e.err       = mis;
      e.chk_rdata = !w || mis;
      e.rdata     = mis ? 32'h0 : mdl[a[7:2]];
      e.due       = cyc + 1 + W;
      if (w && !mis) mdl[a[7:2]] = d;
      sb.push_back(e);
      bus.req   = 1'b1;
      bus.we    = w;
      bus.adr   = a;
      bus.wdata = d;
      @(negedge clk);
      bus.req = 1'b0;
      repeat (W) @(negedge clk);
   endtask

   // Called at a negedge: checks the head entry, then pops it.
   task automatic pop_expect(input logic [31:0] a, input logic [31:0] d);
      check("log_valid_head", bus.log_valid, 1);
      check("log_adr_head", bus.log_adr, a);
      check("log_data_head", bus.log_data, d);
      bus.log_ready = 1'b1;
      @(negedge clk);
      bus.log_ready = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.ready === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_ready", bus.ready, 0);
         end else begin
            e = sb.pop_front();
            check("resp_cycle", cyc, e.due);
            check("resp_err", bus.err, e.err);
            if (e.chk_rdata) check("resp_rdata", bus.rdata, e.rdata);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      bus.req = 1'b0;  bus.we = 1'b0;  bus.adr = '0;  bus.wdata = '0;  bus.log_ready = 1'b0;
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.adr = '0; bus0.wdata = '0; bus0.log_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", bus.ready, 0);
      check("rst_err", bus.err, 0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_log_valid", bus.log_valid, 0);
      check("rst_log_count", bus.log_count, 0);
      check("rst_log_overflow", bus.log_overflow, 0);
      reset = 1'b1;

      // First store and its trace entry.
      access(1'b1, 32'd84, 32'd7);
      check("log_no_fallthrough", bus.log_valid, 0);
      @(negedge clk);
      check("log_valid_after_push", bus.log_valid, 1);
      check("log_adr_84", bus.log_adr, 84);
      check("log_data_7", bus.log_data, 7);
      check("log_count_1", bus.log_count, 1);

      // Back-to-back write then read of the same word.
      access(1'b1, 32'd80, 32'd5);
      access(1'b0, 32'd80, 32'd0);
      check("log_count_2", bus.log_count, 2);
      pop_expect(32'd84, 32'd7);
      pop_expect(32'd80, 32'd5);
      check("log_empty_after_drain", bus.log_valid, 0);

      // Address aliasing and misaligned accesses.
      access(1'b1, 32'h100, 32'hAAAA5555);
      access(1'b0, 32'h102, 32'd0);
      access(1'b1, 32'h101, 32'h0000DEAD);
      access(1'b0, 32'h100, 32'd0);
      access(1'b0, 32'h000, 32'd0);
      @(negedge clk);
      check("log_count_misaligned", bus.log_count, 1);
      pop_expect(32'h100, 32'hAAAA5555);
      check("log_empty_misaligned", bus.log_valid, 0);

      // Overflow with no consumer.
      for (int i = 0; i < 5; i++) access(1'b1, 32'(i * 4), 32'(16 + i));
      @(negedge clk);
      check("ovf_count", bus.log_count, 4);
      check("ovf_flag", bus.log_overflow, 1);
      check("ovf_head", bus.log_adr, 0);
      for (int i = 0; i < 4; i++) pop_expect(32'(i * 4), 32'(16 + i));
      check("ovf_drained", bus.log_valid, 0);
      check("ovf_sticky", bus.log_overflow, 1);

      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("ovf_cleared_by_reset", bus.log_overflow, 0);
      check("count_cleared_by_reset", bus.log_count, 0);

      // Full FIFO with a pop on the same edge as the push.
      for (int i = 0; i < 4; i++) access(1'b1, 32'(20 + 4 * i), 32'(32 + i));
      access(1'b1, 32'd36, 32'd36);
      bus.log_ready = 1'b1;
      @(negedge clk);
      bus.log_ready = 1'b0;
      check("full_pushpop_count", bus.log_count, 4);
      check("full_pushpop_ovf", bus.log_overflow, 0);
      check("full_pushpop_head", bus.log_adr, 24);
      pop_expect(32'd24, 32'd33);
      pop_expect(32'd28, 32'd34);
      pop_expect(32'd32, 32'd35);
      pop_expect(32'd36, 32'd36);
      check("full_pushpop_drained", bus.log_valid, 0);

      // Reset during WAIT discards the pending store.
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b1; bus.adr = 32'd84; bus.wdata = 32'd9;
      @(negedge clk);
      bus.req = 1'b0;
      reset   = 1'b0;
      @(negedge clk);
      check("midrst_ready", bus.ready, 0);
      check("midrst_log_valid", bus.log_valid, 0);
      check("midrst_log_count", bus.log_count, 0);
      check("midrst_ovf", bus.log_overflow, 0);
      reset = 1'b1;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         check("no_ready_after_reset", bus.ready, 0);
      end
      check("midrst_log_still_empty", bus.log_valid, 0);
      access(1'b0, 32'd84, 32'd0);
      repeat (2) @(negedge clk);

      // Zero wait states: response one cycle after the sampling edge.
      bus0.req = 1'b1; bus0.we = 1'b1; bus0.adr = 32'd8; bus0.wdata = 32'h77;
      @(negedge clk);
      bus0.req = 1'b0;
      check("w0_write_ready", bus0.ready, 1);
      check("w0_write_err", bus0.err, 0);
      @(negedge clk);
      check("w0_ready_pulse", bus0.ready, 0);
      check("w0_log_valid", bus0.log_valid, 1);
      check("w0_log_adr", bus0.log_adr, 8);
      check("w0_log_data", bus0.log_data, 32'h77);
      bus0.req = 1'b1; bus0.we = 1'b0; bus0.adr = 32'd8;
      @(negedge clk);
      bus0.req = 1'b0;
      check("w0_read_ready", bus0.ready, 1);
      check("w0_read_rdata", bus0.rdata, 32'h77);

      repeat (2) @(negedge clk);
      check("pending_responses", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
